// File: rtl/int_link_pkg.sv
// Shared definitions for the width-coded interrupt link.
// Used by the transmitter here and by the receive-side decoder.
package int_link_pkg;

   // Link FSM state encoding, shared so both ends agree on the meaning of each value
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ALIGN = 2'd1,
      HIGH  = 2'd2,
      GAP   = 2'd3
   } linkState_e;

   // Code selector values, used as the index of the pend bit for each code
   localparam logic CODE1 = 1'b0;
   localparam logic CODE2 = 1'b1;

   // Default pulse widths and minimum gap, all in 1 us ticks
   localparam int unsigned DEF_W1_US  = 10;
   localparam int unsigned DEF_W2_US  = 30;
   localparam int unsigned DEF_GAP_US = 20;

   // Receiver acceptance windows in ticks, kept here for cross-checking the transmitter widths
   localparam int unsigned RX_W1_MIN = 5;
   localparam int unsigned RX_W1_MAX = 15;
   localparam int unsigned RX_W2_MIN = 25;
   localparam int unsigned RX_W2_MAX = 35;

   // Width of the shared tick counter
   localparam int unsigned CNT_W = 16;

   // Arbiter: choose which pending code goes next; prio2 selects who wins a tie
   function automatic logic pickCode(input logic [1:0] pendBits, input logic prio2);
      logic code;
      if (prio2) begin
         code = pendBits[1] ? CODE2 : CODE1;
      end else begin
         code = pendBits[0] ? CODE1 : CODE2;
      end
      return code;
   endfunction

endpackage

// File: rtl/tick_sync.sv
// Three-flop synchroniser for an asynchronous 1 us strobe, plus a rising-edge detector.
// Produces exactly one clk-wide tick per rise of the incoming strobe.
module tick_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic async_i,
   output logic tick_o
);

   logic [2:0] sync_q;

   // Shift the raw strobe through three flops; the first two resolve metastability
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= 3'b000;
      end else begin
         sync_q <= {sync_q[1:0], async_i};
      end
   end

   // A rise is a 1 in the newer settled stage with a 0 behind it
   assign tick_o = (sync_q[2:1] == 2'b01);

endmodule

// File: rtl/int_width_tx.sv
// Transmit side of the width-coded interrupt line.
// Latches code-1/code-2 requests, arbitrates between them and emits one tick-aligned
// high pulse per request, followed by a forced low gap so the receiver sees clean edges.
module int_width_tx
   import int_link_pkg::*;
#(
   parameter int unsigned W1_US  = DEF_W1_US,
   parameter int unsigned W2_US  = DEF_W2_US,
   parameter int unsigned GAP_US = DEF_GAP_US,
   parameter bit          PRIO2  = 1'b0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       T1us,
   input  logic       en,
   input  logic       req1,
   input  logic       req2,
   output logic       int_o,
   output logic       busy,
   output logic [1:0] pend,
   output logic       done,
   output logic       drop
);

   // Zero or over-range widths would make the down-counter wrap, so refuse them at elaboration
   if (W1_US < 1 || W1_US > 65535) begin : gBadW1
      $error("int_width_tx: W1_US must be 1..65535");
   end
   if (W2_US < 1 || W2_US > 65535) begin : gBadW2
      $error("int_width_tx: W2_US must be 1..65535");
   end
   if (GAP_US < 1 || GAP_US > 65535) begin : gBadGap
      $error("int_width_tx: GAP_US must be 1..65535");
   end

   localparam logic [CNT_W-1:0] W1_CNT  = CNT_W'(W1_US);
   localparam logic [CNT_W-1:0] W2_CNT  = CNT_W'(W2_US);
   localparam logic [CNT_W-1:0] GAP_CNT = CNT_W'(GAP_US);

   logic             tick;
   linkState_e       state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [1:0]       pend_q;
   logic [1:0]       pend_d;
   logic             drop_q;
   logic             drop_d;
   logic             int_q;
   logic             busy_q;
   logic             done_q;
   logic             launch;
   logic             code;
   logic [1:0]       takeMask;
   logic [1:0]       reqBits;

   tick_sync u_tick_sync (
      .clk     (clk),
      .rst_n   (rst_n),
      .async_i (T1us),
      .tick_o  (tick)
   );

   // Arbitration and request latch: a launch consumes its pend bit before new requests are
   // merged in, so a request arriving on the launch cycle re-arms the code for one more pulse
   always_comb begin
      reqBits  = {req2, req1};
      launch   = (state_q == IDLE) && en && (|pend_q);
      code     = pickCode(pend_q, PRIO2);
      takeMask = 2'b00;
      if (launch) begin
         takeMask = (code == CODE2) ? 2'b10 : 2'b01;
      end
      pend_d = (pend_q & ~takeMask) | reqBits;
      drop_d = |(reqBits & pend_q & ~takeMask);
   end

   // Register the pending set and the one-cycle overflow strobe
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_q <= 2'b00;
         drop_q <= 1'b0;
      end else begin
         pend_q <= pend_d;
         drop_q <= drop_d;
      end
   end

   // Pulse FSM: wait for a tick to align the rising edge, count W ticks high, then GAP ticks low;
   // everything after IDLE advances only on ticks so a stalled T1us freezes the line level
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         int_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (launch) begin
                  state_q <= ALIGN;
                  cnt_q   <= (code == CODE2) ? W2_CNT : W1_CNT;
                  busy_q  <= 1'b1;
               end
            end
            ALIGN: begin
               if (tick) begin
                  state_q <= HIGH;
                  int_q   <= 1'b1;
               end
            end
            HIGH: begin
               if (tick) begin
                  if (cnt_q == CNT_W'(1)) begin
                     state_q <= GAP;
                     int_q   <= 1'b0;
                     done_q  <= 1'b1;
                     cnt_q   <= GAP_CNT;
                  end else begin
                     cnt_q <= cnt_q - CNT_W'(1);
                  end
               end
            end
            GAP: begin
               if (tick) begin
                  if (cnt_q == CNT_W'(1)) begin
                     state_q <= IDLE;
                     busy_q  <= 1'b0;
                     cnt_q   <= '0;
                  end else begin
                     cnt_q <= cnt_q - CNT_W'(1);
                  end
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign int_o = int_q;
   assign busy  = busy_q;
   assign pend  = pend_q;
   assign done  = done_q;
   assign drop  = drop_q;

endmodule

// File: tb/tb_int_width_tx.sv
// Self-checking bench for int_width_tx: two instances (PRIO2=0 and PRIO2=1) share stimulus,
// a tick-count timeline model predicts every output each cycle, and directed scenarios pin
// pulse widths, gaps and ordering with hand-computed numbers.
module tb_int_width_tx;
   import int_link_pkg::*;

   localparam int CLK_PER_TICK = 100;
   localparam int W1T  = 10;
   localparam int W2T  = 30;
   localparam int GAPT = 20;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   logic T1us = 1'b0;
   logic en = 1'b1;
   logic req1 = 1'b0;
   logic req2 = 1'b0;

   logic       intO  [2];
   logic       busyO [2];
   logic [1:0] pendO [2];
   logic       doneO [2];
   logic       dropO [2];

   int checks = 0;
   int passes = 0;
   bit checkOn = 1'b0;
   bit tickRun = 1'b1;
   int cyc = 0;

   // Model state: ticks seen by the DUTs and, per instance, the tick index where the current pulse was launched
   logic       h1 = 1'b0, h2 = 1'b0, h3 = 1'b0;
   int         tickCount = 0;
   logic [1:0] mPend   [2] = '{2'b00, 2'b00};
   bit         mActive [2] = '{1'b0, 1'b0};
   bit         mCode   [2] = '{1'b0, 1'b0};
   int         mStart  [2] = '{0, 0};
   logic       eInt    [2] = '{1'b0, 1'b0};
   logic       eBusy   [2] = '{1'b0, 1'b0};
   logic       eDone   [2] = '{1'b0, 1'b0};
   logic       eDrop   [2] = '{1'b0, 1'b0};
   bit         tickNow;
   int         tcNow;
   int         wNow;
   bit         launchM;
   bit         pickM;
   logic [1:0] takeM;
   logic [1:0] reqV;

   // Pulse monitor bookkeeping
   logic prevInt [2] = '{1'b0, 1'b0};
   int   riseAt  [2] = '{0, 0};
   int   fallAt  [2] = '{-1, -1};
   int   riseCount [2] = '{0, 0};
   int   doneCount [2] = '{0, 0};
   int   dropCount [2] = '{0, 0};
   int   widthQ0 [$];
   int   widthQ1 [$];
   int   gapQ0 [$];

   always #5 clk = ~clk;

   int_width_tx #(.W1_US(W1T), .W2_US(W2T), .GAP_US(GAPT), .PRIO2(1'b0)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .T1us(T1us), .en(en), .req1(req1), .req2(req2),
      .int_o(intO[0]), .busy(busyO[0]), .pend(pendO[0]), .done(doneO[0]), .drop(dropO[0])
   );

   int_width_tx #(.W1_US(W1T), .W2_US(W2T), .GAP_US(GAPT), .PRIO2(1'b1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .T1us(T1us), .en(en), .req1(req1), .req2(req2),
      .int_o(intO[1]), .busy(busyO[1]), .pend(pendO[1]), .done(doneO[1]), .drop(dropO[1])
   );

   // 1 us strobe: one clk high every CLK_PER_TICK clocks, suspendable through tickRun
   initial begin
      int phase;
      phase = 0;
      forever begin
         @(negedge clk);
         T1us  = tickRun && (phase == 0);
         phase = (phase + 1) % CLK_PER_TICK;
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual === expected) begin
         passes++;
      end else begin
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   task automatic checkRange(input string name, input int actual, input int lo, input int hi);
      checks++;
      if (actual >= lo && actual <= hi) begin
         passes++;
      end else begin
         $display("[TB] FAIL %s: got %0d, expected %0d..%0d", name, actual, lo, hi);
      end
   endtask

   function automatic int qAt(input int q[$], input int idx);
      return (idx < q.size()) ? q[idx] : -1;
   endfunction

   // Behavioural model: a T1us rise becomes visible to the DUT two sampling edges later; a
   // pulse launched when the tick count is S is high for tick counts S+1 .. S+W and busy until S+1+W+GAP
   always @(posedge clk) begin
      if (!rst_n) begin
         h1 = 1'b0; h2 = 1'b0; h3 = 1'b0;
         for (int i = 0; i < 2; i++) begin
            mPend[i] = 2'b00; mActive[i] = 1'b0;
            eInt[i] = 1'b0; eBusy[i] = 1'b0; eDone[i] = 1'b0; eDrop[i] = 1'b0;
         end
      end else begin
         tickNow = h2 && !h3;
         h3 = h2; h2 = h1; h1 = T1us;
         if (tickNow) tickCount++;
         tcNow = tickCount;
         reqV  = {req2, req1};
         for (int i = 0; i < 2; i++) begin
            launchM = !mActive[i] && en && (mPend[i] != 2'b00);
            if (mActive[i]) begin
               wNow = mCode[i] ? W2T : W1T;
               if (tcNow >= mStart[i] + 1 + wNow + GAPT) mActive[i] = 1'b0;
            end
            takeM = 2'b00;
            if (launchM) begin
               if (i == 1) pickM = mPend[i][1];
               else        pickM = !mPend[i][0];
               takeM      = pickM ? 2'b10 : 2'b01;
               mActive[i] = 1'b1;
               mCode[i]   = pickM;
               mStart[i]  = tcNow;
            end
            eDrop[i] = |(reqV & mPend[i] & ~takeM);
            mPend[i] = (mPend[i] & ~takeM) | reqV;
            if (mActive[i]) begin
               wNow     = mCode[i] ? W2T : W1T;
               eInt[i]  = (tcNow >= mStart[i] + 1) && (tcNow < mStart[i] + 1 + wNow);
               eDone[i] = tickNow && (tcNow == mStart[i] + 1 + wNow);
               eBusy[i] = 1'b1;
            end else begin
               eInt[i] = 1'b0; eDone[i] = 1'b0; eBusy[i] = 1'b0;
            end
         end
      end
   end

   // Compare every output against the model shortly after each edge, and log pulse edges
   always @(posedge clk) begin
      #2;
      cyc++;
      for (int i = 0; i < 2; i++) begin
         if (checkOn) begin
            checkOutput($sformatf("u%0d int_o @%0d", i, cyc), intO[i], eInt[i]);
            checkOutput($sformatf("u%0d busy @%0d", i, cyc), busyO[i], eBusy[i]);
            checkOutput($sformatf("u%0d pend @%0d", i, cyc), pendO[i], mPend[i]);
            checkOutput($sformatf("u%0d done @%0d", i, cyc), doneO[i], eDone[i]);
            checkOutput($sformatf("u%0d drop @%0d", i, cyc), dropO[i], eDrop[i]);
         end
         if (intO[i] === 1'b1 && prevInt[i] !== 1'b1) begin
            riseCount[i]++;
            if (i == 0 && fallAt[0] >= 0) gapQ0.push_back(cyc - fallAt[0]);
            riseAt[i] = cyc;
         end
         if (intO[i] === 1'b0 && prevInt[i] === 1'b1) begin
            if (i == 0) widthQ0.push_back(cyc - riseAt[0]);
            else        widthQ1.push_back(cyc - riseAt[1]);
            fallAt[i] = cyc;
         end
         if (doneO[i] === 1'b1) doneCount[i]++;
         if (dropO[i] === 1'b1) dropCount[i]++;
         prevInt[i] = intO[i];
      end
   end

   task automatic clearMon();
      widthQ0.delete(); widthQ1.delete(); gapQ0.delete();
      fallAt[0] = -1; fallAt[1] = -1;
      for (int i = 0; i < 2; i++) begin
         riseCount[i] = 0; doneCount[i] = 0; dropCount[i] = 0;
      end
   endtask

   task automatic applyStimulus(input logic r1, input logic r2);
      @(negedge clk);
      req1 = r1;
      req2 = r2;
      @(negedge clk);
      req1 = 1'b0;
      req2 = 1'b0;
   endtask

   task automatic waitTicks(input int n);
      repeat (n * CLK_PER_TICK) @(negedge clk);
   endtask

   // Directed scenarios followed by a randomized soak
   initial begin
      int snap;
      int waited;
      int ticksMeas;

      #3 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      checkOn = 1'b1;
      checkOutput("reset int_o", intO[0], 0);
      checkOutput("reset busy", busyO[0], 0);
      checkOutput("reset pend", pendO[0], 0);
      checkOutput("reset done", doneO[0], 0);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);

      $display("[TB] T1 single code-1 pulse");
      clearMon();
      applyStimulus(1'b1, 1'b0);
      waitTicks(35);
      checkOutput("T1 pulse count", widthQ0.size(), 1);
      checkRange("T1 width clk", qAt(widthQ0, 0), 999, 1001);
      checkOutput("T1 done count", doneCount[0], 1);
      checkOutput("T1 pend idle", pendO[0], 0);
      checkOutput("T1 busy idle", busyO[0], 0);

      $display("[TB] T2 single code-2 pulse");
      clearMon();
      applyStimulus(1'b0, 1'b1);
      waitTicks(55);
      checkRange("T2 width clk", qAt(widthQ0, 0), 2999, 3001);
      ticksMeas = (qAt(widthQ0, 0) + CLK_PER_TICK / 2) / CLK_PER_TICK;
      checkOutput("T2 decoder INT2", (ticksMeas >= RX_W2_MIN && ticksMeas <= RX_W2_MAX), 1);
      checkOutput("T2 decoder INT1", (ticksMeas >= RX_W1_MIN && ticksMeas <= RX_W1_MAX), 0);

      $display("[TB] T3 simultaneous requests");
      clearMon();
      applyStimulus(1'b1, 1'b1);
      checkOutput("T3 u0 pend both", pendO[0], 3);
      checkOutput("T3 u1 pend both", pendO[1], 3);
      @(negedge clk);
      checkOutput("T3 u0 pend after pick", pendO[0], 2);
      checkOutput("T3 u1 pend after pick", pendO[1], 1);
      waitTicks(90);
      checkOutput("T3 u0 pulse count", widthQ0.size(), 2);
      checkRange("T3 u0 first width", qAt(widthQ0, 0), 999, 1001);
      checkRange("T3 u0 second width", qAt(widthQ0, 1), 2999, 3001);
      checkRange("T3 u0 gap", qAt(gapQ0, 0), 2000, 2101);
      checkOutput("T3 u1 pulse count", widthQ1.size(), 2);
      checkRange("T3 u1 first width", qAt(widthQ1, 0), 2999, 3001);
      checkRange("T3 u1 second width", qAt(widthQ1, 1), 999, 1001);
      checkOutput("T3 u0 pend empty", pendO[0], 0);

      $display("[TB] T4 re-request during pulse");
      clearMon();
      applyStimulus(1'b1, 1'b0);
      waitTicks(5);
      applyStimulus(1'b1, 1'b0);
      waitTicks(2);
      applyStimulus(1'b1, 1'b0);
      waitTicks(70);
      checkOutput("T4 pulse count", widthQ0.size(), 2);
      checkOutput("T4 drop count", dropCount[0], 1);
      checkRange("T4 second width", qAt(widthQ0, 1), 999, 1001);
      checkRange("T4 gap clk", qAt(gapQ0, 0), 2000, 2101);

      $display("[TB] T5 reset mid-pulse");
      clearMon();
      applyStimulus(1'b0, 1'b1);
      waitTicks(6);
      checkOutput("T5 high before reset", intO[0], 1);
      rst_n = 1'b0;
      #1;
      checkOutput("T5 int_o in reset", intO[0], 0);
      checkOutput("T5 busy in reset", busyO[0], 0);
      checkOutput("T5 pend in reset", pendO[0], 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      snap = riseCount[0];
      waitTicks(40);
      checkOutput("T5 no pulse after reset", riseCount[0], snap);

      $display("[TB] T6 enable gating and stalled tick");
      clearMon();
      en = 1'b0;
      applyStimulus(1'b1, 1'b0);
      waitTicks(100);
      checkOutput("T6 no pulse while disabled", riseCount[0], 0);
      checkOutput("T6 pend held", pendO[0], 1);
      checkOutput("T6 idle while disabled", busyO[0], 0);
      en = 1'b1;
      waited = 0;
      while (intO[0] !== 1'b1 && waited < 300) begin
         @(posedge clk);
         #2;
         waited++;
      end
      checkRange("T6 rise after enable", waited, 1, 102);
      waitTicks(3);
      tickRun = 1'b0;
      snap = doneCount[0];
      repeat (1000) @(negedge clk);
      checkOutput("T6 high while stalled", intO[0], 1);
      checkOutput("T6 no done while stalled", doneCount[0], snap);
      tickRun = 1'b1;
      waitTicks(35);
      checkOutput("T6 done after resume", doneCount[0], snap + 1);
      checkOutput("T6 low after resume", intO[0], 0);

      $display("[TB] random soak");
      for (int c = 0; c < 12000; c++) begin
         @(negedge clk);
         req1 = ($urandom_range(0, 299) == 0);
         req2 = ($urandom_range(0, 299) == 0);
         if (c % 2000 == 0) en = ($urandom_range(0, 3) != 0);
      end
      @(negedge clk);
      req1 = 1'b0;
      req2 = 1'b0;
      en   = 1'b1;
      repeat (10) @(negedge clk);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
